// File: rtl/rf_writeback_queue_pkg.sv
// Shared definitions for the register-file writeback queue.
//   WB_AW / WB_DW : default register index / data widths (32x32 register file)
//   REG_ZERO      : hard-wired zero register; writes to it are discarded
//   wb_entry_t    : one pending write {valid, rW, w}
package rf_writeback_queue_pkg;

  localparam int         WB_AW    = 5;
  localparam int         WB_DW    = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic             valid;
    logic [WB_AW-1:0] rW;
    logic [WB_DW-1:0] w;
  } wb_entry_t;

endpackage

// File: rtl/rf_writeback_queue_if.sv
// Writeback bus between the pipeline and the writeback queue.
//   in_valid/in_ready/in_rW/in_w : request handshake from the pipeline
//   rf_WE/rf_rW/rf_w             : register file write port (RF samples on negedge)
// master = pipeline / RF side, slave = writeback queue.
interface rf_writeback_queue_if
  import rf_writeback_queue_pkg::*;
#(
  parameter int AW = WB_AW,
  parameter int DW = WB_DW
);

  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_rW;
  logic [DW-1:0] in_w;
  logic          rf_WE;
  logic [AW-1:0] rf_rW;
  logic [DW-1:0] rf_w;

  modport master (
    output in_valid, in_rW, in_w,
    input  in_ready, rf_WE, rf_rW, rf_w
  );

  modport slave (
    input  in_valid, in_rW, in_w,
    output in_ready, rf_WE, rf_rW, rf_w
  );

endinterface

// File: rtl/rf_fwd_lookup.sv
// Forwarding lookup over the pending-write entries.
//   valid/rw/data : entry storage, indexed by slot
//   rd_ptr        : slot of the oldest entry
//   q             : register index being looked up
//   hit/fwd       : a pending entry targets q / data of the youngest such entry
// Register zero never hits.
module rf_fwd_lookup
  import rf_writeback_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int AW    = WB_AW,
  parameter  int DW    = WB_DW,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]         valid,
  input  logic [DEPTH-1:0][AW-1:0] rw,
  input  logic [DEPTH-1:0][DW-1:0] data,
  input  logic [PW-1:0]            rd_ptr,
  input  logic [AW-1:0]            q,
  output logic                     hit,
  output logic [DW-1:0]            fwd
);

  logic [PW-1:0] idx;

  // Walk from oldest to youngest; a later match overwrites an earlier one,
  // so the youngest matching entry wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    hit = 1'b0;
    fwd = '0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (valid[idx] && (rw[idx] == q) && (q != AW'(REG_ZERO))) begin
        hit = 1'b1;
        fwd = data[idx];
      end
    end
  end

endmodule

// File: rtl/rf_writeback_queue.sv
// Writeback queue in front of the 32x32 register file write port.
//   clk, rst        : clock, synchronous active-high reset
//   wb (slave)      : request handshake in, RF write port out
//   drain_en        : head may retire this cycle
//   flush           : drop all pending entries (and any concurrent push)
//   qA/hitA/fwdA    : forwarding lookup A
//   qB/hitB/fwdB    : forwarding lookup B
//   count           : number of pending entries
// Requests to register zero complete the handshake but are never enqueued.
module rf_writeback_queue
  import rf_writeback_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int AW    = WB_AW,
  parameter  int DW    = WB_DW,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  rf_writeback_queue_if.slave   wb,
  input  logic                  drain_en,
  input  logic                  flush,
  input  logic [AW-1:0]         qA,
  output logic                  hitA,
  output logic [DW-1:0]         fwdA,
  input  logic [AW-1:0]         qB,
  output logic                  hitB,
  output logic [DW-1:0]         fwdB,
  output logic [CW-1:0]         count
);

  logic [DEPTH-1:0]         ent_valid;
  logic [DEPTH-1:0][AW-1:0] ent_rw;
  logic [DEPTH-1:0][DW-1:0] ent_w;
  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;

  logic full;
  logic empty;
  logic enq;
  logic pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // No full-bypass: a pop never frees a slot for a push in the same cycle.
  assign wb.in_ready = !full;

  // Flushed or register-zero requests still complete the handshake.
  assign enq = wb.in_valid && !full && (wb.in_rW != AW'(REG_ZERO)) && !flush;

  // The RF samples on negedge, so the head is written mid-cycle and popped at
  // the following posedge.
  assign pop      = !empty && drain_en && !flush && !rst;
  assign wb.rf_WE = pop;
  assign wb.rf_rW = pop ? ent_rw[rd_ptr] : '0;
  assign wb.rf_w  = pop ? ent_w[rd_ptr]  : '0;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (enq) begin
        ent_valid[wr_ptr] <= 1'b1;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + PW'(1);
      end
      count <= count + CW'(enq) - CW'(pop);
    end
  end

  // NOTE: entry payload is not reset; it is only observed through ent_valid.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_rw[wr_ptr] <= wb.in_rW;
      ent_w[wr_ptr]  <= wb.in_w;
    end
  end

  rf_fwd_lookup #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_lookup_a (
    .valid  (ent_valid),
    .rw     (ent_rw),
    .data   (ent_w),
    .rd_ptr (rd_ptr),
    .q      (qA),
    .hit    (hitA),
    .fwd    (fwdA)
  );

  rf_fwd_lookup #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_lookup_b (
    .valid  (ent_valid),
    .rw     (ent_rw),
    .data   (ent_w),
    .rd_ptr (rd_ptr),
    .q      (qB),
    .hit    (hitB),
    .fwd    (fwdB)
  );

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Self-checking bench for rf_writeback_queue: directed vector table, a short
// wrap-around sequence and randomized traffic, all compared against a
// queue-based reference model and a model of the register file.
module tb_rf_writeback_queue;
  import rf_writeback_queue_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        drain_en;
  logic        flush;
  logic [4:0]  qA, qB;
  logic        hitA, hitB;
  logic [31:0] fwdA, fwdB;
  logic [2:0]  count;

  rf_writeback_queue_if #(.AW(WB_AW), .DW(WB_DW)) wb ();

  rf_writeback_queue #(.DEPTH(DEPTH), .AW(WB_AW), .DW(WB_DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .wb       (wb),
    .drain_en (drain_en),
    .flush    (flush),
    .qA       (qA),
    .hitA     (hitA),
    .fwdA     (fwdA),
    .qB       (qB),
    .hitB     (hitB),
    .fwdB     (fwdB),
    .count    (count)
  );

  always #5 clk = ~clk;

  // Register file as seen by the queue: captures on negedge.
  logic [31:0] rf_mem [32];
  // Register file contents expected from the reference model.
  logic [31:0] ref_rf [32];

  always @(negedge clk) begin
    if (wb.rf_WE === 1'b1) rf_mem[wb.rf_rW] = wb.rf_w;
  end

  // Reference model: pending writes in issue order, front = oldest.
  wb_entry_t mq[$];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          rst;
    bit          vld;
    logic [4:0]  rw;
    logic [31:0] w;
    bit          drain;
    bit          flush;
    logic [4:0]  qa;
    logic [4:0]  qb;
    bit          e_ready;
    bit          e_we;
    logic [4:0]  e_rrw;
    logic [31:0] e_rw;
    bit          e_hita;
    logic [31:0] e_fwda;
    bit          e_hitb;
    logic [31:0] e_fwdb;
    int          e_count;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit r, input bit v, input int rw, input int w,
                              input bit dr, input bit fl, input int qa, input int qb,
                              input bit rdy, input bit we, input int rrw, input int rdat,
                              input bit ha, input int fa, input bit hb, input int fb,
                              input int cnt);
    vec_t x;
    x.rst = r;  x.vld = v;  x.rw = 5'(rw); x.w = 32'(w);
    x.drain = dr; x.flush = fl; x.qa = 5'(qa); x.qb = 5'(qb);
    x.e_ready = rdy; x.e_we = we; x.e_rrw = 5'(rrw); x.e_rw = 32'(rdat);
    x.e_hita = ha; x.e_fwda = 32'(fa); x.e_hitb = hb; x.e_fwdb = 32'(fb);
    x.e_count = cnt;
    return x;
  endfunction

  // Youngest pending write to q; register zero never matches.
  function automatic void model_lookup(input logic [4:0] q, output bit h, output logic [31:0] d);
    h = 1'b0;
    d = '0;
    if (q != 5'd0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].rW == q) begin
          h = 1'b1;
          d = mq[i].w;
          break;
        end
      end
    end
  endfunction

  // Drive one cycle, compare against the model (and the vector's own
  // expectations if use_exp), then advance the model past the posedge.
  task automatic drive_cycle(input vec_t v, input bit use_exp, input string tag);
    bit          m_ready, m_we, m_ha, m_hb;
    logic [4:0]  m_rrw;
    logic [31:0] m_rw, m_fa, m_fb;
    int          m_cnt;

    rst         = v.rst;
    wb.in_valid = v.vld;
    wb.in_rW    = v.rw;
    wb.in_w     = v.w;
    drain_en    = v.drain;
    flush       = v.flush;
    qA          = v.qa;
    qB          = v.qb;
    #1;

    m_cnt   = mq.size();
    m_ready = (m_cnt < DEPTH);
    m_we    = (m_cnt != 0) && v.drain && !v.flush && !v.rst;
    m_rrw   = m_we ? mq[0].rW : 5'd0;
    m_rw    = m_we ? mq[0].w  : 32'd0;
    model_lookup(v.qa, m_ha, m_fa);
    model_lookup(v.qb, m_hb, m_fb);

    check({tag, ".count"},    32'(count),       32'(m_cnt));
    check({tag, ".in_ready"}, 32'(wb.in_ready), 32'(m_ready));
    check({tag, ".rf_WE"},    32'(wb.rf_WE),    32'(m_we));
    check({tag, ".rf_rW"},    32'(wb.rf_rW),    32'(m_rrw));
    check({tag, ".rf_w"},     wb.rf_w,          m_rw);
    check({tag, ".hitA"},     32'(hitA),        32'(m_ha));
    check({tag, ".fwdA"},     fwdA,             m_fa);
    check({tag, ".hitB"},     32'(hitB),        32'(m_hb));
    check({tag, ".fwdB"},     fwdB,             m_fb);

    if (use_exp) begin
      check({tag, ".vec_count"}, 32'(count),       32'(v.e_count));
      check({tag, ".vec_ready"}, 32'(wb.in_ready), 32'(v.e_ready));
      check({tag, ".vec_WE"},    32'(wb.rf_WE),    32'(v.e_we));
      check({tag, ".vec_rW"},    32'(wb.rf_rW),    32'(v.e_rrw));
      check({tag, ".vec_w"},     wb.rf_w,          v.e_rw);
      check({tag, ".vec_hitA"},  32'(hitA),        32'(v.e_hita));
      check({tag, ".vec_fwdA"},  fwdA,             v.e_fwda);
      check({tag, ".vec_hitB"},  32'(hitB),        32'(v.e_hitb));
      check({tag, ".vec_fwdB"},  fwdB,             v.e_fwdb);
    end

    @(posedge clk);
    if (v.rst || v.flush) begin
      mq.delete();
    end else begin
      if (m_we) begin
        ref_rf[mq[0].rW] = mq[0].w;
        void'(mq.pop_front());
      end
      if (v.vld && m_ready && (v.rw != 5'd0))
        mq.push_back(wb_entry_t'{valid: 1'b1, rW: v.rw, w: v.w});
    end
    #1;
  endtask

  initial begin
    vec_t v;
    int   exp_rf [int];

    for (int i = 0; i < 32; i++) begin
      rf_mem[i] = '0;
      ref_rf[i] = '0;
    end

    // ---- reset ----
    rst = 1'b1; wb.in_valid = 1'b0; wb.in_rW = '0; wb.in_w = '0;
    drain_en = 1'b1; flush = 1'b0; qA = 5'd5; qB = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("reset.count",    32'(count),       32'd0);
    check("reset.in_ready", 32'(wb.in_ready), 32'd1);
    check("reset.rf_WE",    32'(wb.rf_WE),    32'd0);
    check("reset.rf_rW",    32'(wb.rf_rW),    32'd0);
    check("reset.rf_w",     wb.rf_w,          32'd0);
    check("reset.hitA",     32'(hitA),        32'd0);
    check("reset.hitB",     32'(hitB),        32'd0);
    check("reset.fwdA",     fwdA,             32'd0);
    check("reset.fwdB",     fwdB,             32'd0);
    @(posedge clk);
    #1;

    // ---- directed vector table ----
    //               rst vld rW  w        dr fl qa qb   rdy we rrw rdat    ha fa      hb fb     cnt
    // single push, one-cycle latency to the RF port
    tbl.push_back(mk(0, 1,  5, 'hAA,     1, 0, 5, 0,   1, 0, 0, 0,       0, 0,      0, 0,     0));
    tbl.push_back(mk(0, 0,  0, 0,        1, 0, 5, 0,   1, 1, 5, 'hAA,    1, 'hAA,   0, 0,     1));
    tbl.push_back(mk(0, 0,  0, 0,        1, 0, 5, 0,   1, 0, 0, 0,       0, 0,      0, 0,     0));
    // fill with drain held off, youngest-match forwarding, 5th push refused
    tbl.push_back(mk(0, 1,  3, 'h11,     0, 0, 0, 0,   1, 0, 0, 0,       0, 0,      0, 0,     0));
    tbl.push_back(mk(0, 1,  3, 'h22,     0, 0, 3, 0,   1, 0, 0, 0,       1, 'h11,   0, 0,     1));
    tbl.push_back(mk(0, 1,  7, 'h33,     0, 0, 3, 0,   1, 0, 0, 0,       1, 'h22,   0, 0,     2));
    tbl.push_back(mk(0, 1,  9, 'h44,     0, 0, 7, 0,   1, 0, 0, 0,       1, 'h33,   0, 0,     3));
    tbl.push_back(mk(0, 1, 10, 'h55,     0, 0, 3, 8,   0, 0, 0, 0,       1, 'h22,   0, 0,     4));
    // drain in issue order
    tbl.push_back(mk(0, 0,  0, 0,        1, 0, 3, 9,   0, 1, 3, 'h11,    1, 'h22,   1, 'h44,  4));
    tbl.push_back(mk(0, 0,  0, 0,        1, 0, 3, 9,   1, 1, 3, 'h22,    1, 'h22,   1, 'h44,  3));
    tbl.push_back(mk(0, 0,  0, 0,        1, 0, 3, 7,   1, 1, 7, 'h33,    0, 0,      1, 'h33,  2));
    tbl.push_back(mk(0, 0,  0, 0,        1, 0, 3, 9,   1, 1, 9, 'h44,    0, 0,      1, 'h44,  1));
    tbl.push_back(mk(0, 0,  0, 0,        1, 0, 9, 0,   1, 0, 0, 0,       0, 0,      0, 0,     0));
    // register zero is accepted but dropped
    tbl.push_back(mk(0, 1,  0, 'hDEAD,   1, 0, 0, 0,   1, 0, 0, 0,       0, 0,      0, 0,     0));
    tbl.push_back(mk(0, 0,  0, 0,        1, 0, 0, 0,   1, 0, 0, 0,       0, 0,      0, 0,     0));
    // flush with a concurrent push
    tbl.push_back(mk(0, 1,  1, 'h101,    0, 0, 0, 0,   1, 0, 0, 0,       0, 0,      0, 0,     0));
    tbl.push_back(mk(0, 1,  2, 'h202,    0, 0, 1, 0,   1, 0, 0, 0,       1, 'h101,  0, 0,     1));
    tbl.push_back(mk(0, 1,  1, 'h303,    0, 0, 1, 2,   1, 0, 0, 0,       1, 'h101,  1, 'h202, 2));
    tbl.push_back(mk(0, 1,  4, 'h404,    1, 1, 1, 2,   1, 0, 0, 0,       1, 'h303,  1, 'h202, 3));
    tbl.push_back(mk(0, 0,  0, 0,        1, 0, 4, 1,   1, 0, 0, 0,       0, 0,      0, 0,     0));
    tbl.push_back(mk(0, 0,  0, 0,        1, 0, 1, 2,   1, 0, 0, 0,       0, 0,      0, 0,     0));
    // reset with two pending
    tbl.push_back(mk(0, 1,  6, 'h66,     0, 0, 0, 0,   1, 0, 0, 0,       0, 0,      0, 0,     0));
    tbl.push_back(mk(0, 1,  8, 'h88,     0, 0, 6, 0,   1, 0, 0, 0,       1, 'h66,   0, 0,     1));
    tbl.push_back(mk(1, 0,  0, 0,        0, 0, 0, 0,   1, 0, 0, 0,       0, 0,      0, 0,     2));
    tbl.push_back(mk(0, 0,  0, 0,        1, 0, 6, 8,   1, 0, 0, 0,       0, 0,      0, 0,     0));

    foreach (tbl[i]) drive_cycle(tbl[i], 1'b1, $sformatf("vec%0d", i));

    // RF contents after the directed part: younger r3 wins, dropped writes absent.
    exp_rf[5] = 'hAA;  exp_rf[3] = 'h22; exp_rf[7] = 'h33; exp_rf[9] = 'h44;
    exp_rf[10] = 0;    exp_rf[0] = 0;    exp_rf[1] = 0;    exp_rf[2] = 0;
    exp_rf[4] = 0;     exp_rf[6] = 0;    exp_rf[8] = 0;
    foreach (exp_rf[r]) check($sformatf("rf_dir[%0d]", r), rf_mem[r], 32'(exp_rf[r]));

    // ---- wrap-around: alternating push/pop with drain_en toggling ----
    for (int i = 0; i < 10; i++) begin
      v = mk(0, (i % 2 == 0) || (i < 4), 11 + (i % 3), 'h1000 + i, (i % 2 == 1), 0,
             11 + (i % 3), 12, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive_cycle(v, 1'b0, $sformatf("wrap%0d", i));
    end
    for (int i = 0; i < 6; i++) begin
      v = mk(0, 0, 0, 0, 1, 0, 11, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive_cycle(v, 1'b0, $sformatf("wrapd%0d", i));
    end

    // ---- randomized traffic ----
    for (int i = 0; i < 400; i++) begin
      v = mk(($urandom_range(0, 79) == 0), ($urandom_range(0, 99) < 60),
             ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 15), $urandom,
             ($urandom_range(0, 99) < 55), ($urandom_range(0, 29) == 0),
             $urandom_range(0, 15), $urandom_range(0, 15),
             0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (mq.size() > 0 && $urandom_range(0, 1) == 1)
        v.qa = mq[$urandom_range(0, mq.size() - 1)].rW;
      if (mq.size() > 0 && $urandom_range(0, 1) == 1)
        v.qb = mq[$urandom_range(0, mq.size() - 1)].rW;
      drive_cycle(v, 1'b0, $sformatf("rnd%0d", i));
    end
    // drain whatever remains
    for (int i = 0; i < 6; i++) begin
      v = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive_cycle(v, 1'b0, $sformatf("fin%0d", i));
    end

    for (int r = 0; r < 32; r++) check($sformatf("rf_final[%0d]", r), rf_mem[r], ref_rf[r]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
